// File: rtl/seg_pkg.sv
// Shared segment constants for the multiplexed 7-segment scan driver.
// Codes are listed in {a,b,c,d,e,f,g} order, bit 6 = segment a.
package seg_pkg;

  localparam logic [6:0] SEG_0   = 7'b1111110;
  localparam logic [6:0] SEG_1   = 7'b0110000;
  localparam logic [6:0] SEG_2   = 7'b1101101;
  localparam logic [6:0] SEG_3   = 7'b1111001;
  localparam logic [6:0] SEG_4   = 7'b0110011;
  localparam logic [6:0] SEG_5   = 7'b1011011;
  localparam logic [6:0] SEG_6   = 7'b1011111;
  localparam logic [6:0] SEG_7   = 7'b1110000;
  localparam logic [6:0] SEG_8   = 7'b1111111;
  localparam logic [6:0] SEG_9   = 7'b1111011;
  localparam logic [6:0] SEG_A   = 7'b1110111;
  localparam logic [6:0] SEG_B   = 7'b0011111;
  localparam logic [6:0] SEG_C   = 7'b1001110;
  localparam logic [6:0] SEG_D   = 7'b0111101;
  localparam logic [6:0] SEG_E   = 7'b1001111;
  localparam logic [6:0] SEG_F   = 7'b1000111;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [7:0] SEG_BLANK = 8'b0;

  typedef enum logic {
    BLINK_ON  = 1'b0,
    BLINK_OFF = 1'b1
  } blink_phase_e;

endpackage

// File: rtl/seg7_lut.sv
// Combinational 4-bit code to 7-segment decoder.
// Codes 10..15 decode to A..F only when hex_en_i is set, otherwise blank.
module seg7_lut
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       hex_en_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      4'd0:  seg_o = SEG_0;
      4'd1:  seg_o = SEG_1;
      4'd2:  seg_o = SEG_2;
      4'd3:  seg_o = SEG_3;
      4'd4:  seg_o = SEG_4;
      4'd5:  seg_o = SEG_5;
      4'd6:  seg_o = SEG_6;
      4'd7:  seg_o = SEG_7;
      4'd8:  seg_o = SEG_8;
      4'd9:  seg_o = SEG_9;
      4'd10: seg_o = hex_en_i ? SEG_A : SEG_OFF;
      4'd11: seg_o = hex_en_i ? SEG_B : SEG_OFF;
      4'd12: seg_o = hex_en_i ? SEG_C : SEG_OFF;
      4'd13: seg_o = hex_en_i ? SEG_D : SEG_OFF;
      4'd14: seg_o = hex_en_i ? SEG_E : SEG_OFF;
      4'd15: seg_o = hex_en_i ? SEG_F : SEG_OFF;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 7-segment display driver with double-buffered data,
// leading-zero blanking, per-digit blink and an anti-ghost dead time per slot.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int DIGITS       = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 50,
  parameter int HEX_EN       = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   bcd,
  input  logic [DIGITS-1:0]     dots,
  input  logic                  lz_en,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [7:0]            seg_data,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_start,
  output logic                  upd_ack
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DIGITS);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGITS - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES);
  localparam logic          HEX_ON     = (HEX_EN != 0);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [FW-1:0]         frames_q, frames_d;
  blink_phase_e          blink_q, blink_d;
  logic [4*DIGITS-1:0]   actBcd_q, actBcd_d, pendBcd_q, pendBcd_d;
  logic [DIGITS-1:0]     actDots_q, actDots_d, pendDots_q, pendDots_d;
  logic                  pend_q, pend_d;
  logic [7:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     sel_q, sel_d;
  logic                  fs_q, fs_d;
  logic                  ack_q, ack_d;

  logic                  frameEdge;
  logic                  inDead;
  logic [3:0]            curCode;
  logic                  curDot;
  logic                  curLz;
  logic                  curBlink;
  logic                  zeroRun;
  logic [6:0]            curSeg;

  // The counters name the position whose outputs are registered at this edge.
  assign frameEdge = (slot_q == '0) && (cnt_q == '0);

  generate
    if (DEAD == 0) begin : g_nodead
      assign inDead = 1'b0;
    end else begin : g_dead
      localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
      assign inDead = (cnt_q < DEAD_C);
    end
  endgenerate

  always_comb begin
    cnt_d  = cnt_q + 1'b1;
    slot_d = slot_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
    end
  end

  // A load seen on the frame edge itself goes straight to the active buffer,
  // since the frame it starts is strictly after the cycle that carried it.
  always_comb begin
    actBcd_d   = actBcd_q;
    actDots_d  = actDots_q;
    pendBcd_d  = pendBcd_q;
    pendDots_d = pendDots_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;
    if (frameEdge) begin
      if (load) begin
        actBcd_d  = bcd;
        actDots_d = dots;
        pend_d    = 1'b0;
        ack_d     = 1'b1;
      end else if (pend_q) begin
        actBcd_d  = pendBcd_q;
        actDots_d = pendDots_q;
        pend_d    = 1'b0;
        ack_d     = 1'b1;
      end
    end else if (load) begin
      pendBcd_d  = bcd;
      pendDots_d = dots;
      pend_d     = 1'b1;
    end
  end

  always_comb begin
    frames_d = frames_q;
    blink_d  = blink_q;
    if (frameEdge) begin
      if (frames_q == BLINK_LAST) begin
        frames_d = FW'(1);
        blink_d  = (blink_q == BLINK_ON) ? BLINK_OFF : BLINK_ON;
      end else begin
        frames_d = frames_q + 1'b1;
      end
    end
  end

  // Walk from the most significant digit down so zeroRun tracks "this and all above are 0".
  always_comb begin
    curCode  = 4'd0;
    curDot   = 1'b0;
    curLz    = 1'b0;
    curBlink = 1'b0;
    zeroRun  = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zeroRun = zeroRun && (actBcd_d[4*k +: 4] == 4'd0);
      if (slot_q == SW'(k)) begin
        curCode  = actBcd_d[4*k +: 4];
        curDot   = actDots_d[k];
        curLz    = lz_en && zeroRun && (k != 0);
        curBlink = blink_mask[k];
      end
    end
  end

  seg7_lut u_lut (
    .code_i   (curCode),
    .hex_en_i (HEX_ON),
    .seg_o    (curSeg)
  );

  always_comb begin
    sel_d = '0;
    seg_d = SEG_BLANK;
    fs_d  = frameEdge;
    if (!inDead) begin
      sel_d = {{(DIGITS-1){1'b0}}, 1'b1} << slot_q;
      if ((blink_d == BLINK_OFF) && curBlink) begin
        seg_d = SEG_BLANK;
      end else if (curLz) begin
        seg_d = {SEG_OFF, curDot};
      end else begin
        seg_d = {curSeg, curDot};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      slot_q     <= '0;
      frames_q   <= '0;
      blink_q    <= BLINK_ON;
      actBcd_q   <= '0;
      actDots_q  <= '0;
      pendBcd_q  <= '0;
      pendDots_q <= '0;
      pend_q     <= 1'b0;
      seg_q      <= '0;
      sel_q      <= '0;
      fs_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      slot_q     <= slot_d;
      frames_q   <= frames_d;
      blink_q    <= blink_d;
      actBcd_q   <= actBcd_d;
      actDots_q  <= actDots_d;
      pendBcd_q  <= pendBcd_d;
      pendDots_q <= pendDots_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
      fs_q       <= fs_d;
      ack_q      <= ack_d;
    end
  end

  assign seg_data    = seg_q;
  assign digit_sel   = sel_q;
  assign frame_start = fs_q;
  assign upd_ack     = ack_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, SCAN_DIV=4, DEAD=1, BLINK_FRAMES=2.
// pos counts cycles since the first frame_start after the latest reset (16 cycles per frame).
module tb_seg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] bcd;
  logic [3:0]  dots;
  logic        lz_en;
  logic [3:0]  blink_mask;

  logic [7:0]  segData0, segData1;
  logic [3:0]  digitSel0, digitSel1;
  logic        frameStart0, frameStart1;
  logic        updAck0, updAck1;

  int checks = 0;
  int errors = 0;
  int pos    = 0;

  seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .DEAD(1), .BLINK_FRAMES(2), .HEX_EN(0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd(bcd), .dots(dots),
    .lz_en(lz_en), .blink_mask(blink_mask), .seg_data(segData0),
    .digit_sel(digitSel0), .frame_start(frameStart0), .upd_ack(updAck0)
  );

  seg_scan_driver #(
    .DIGITS(4), .SCAN_DIV(4), .DEAD(1), .BLINK_FRAMES(2), .HEX_EN(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .bcd(bcd), .dots(dots),
    .lz_en(lz_en), .blink_mask(blink_mask), .seg_data(segData1),
    .digit_sel(digitSel1), .frame_start(frameStart1), .upd_ack(updAck1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s at pos %0d: observed=%0h expected=%0h", tag, pos, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expSel, input logic [7:0] expSeg,
                             input logic expFs, input logic expAck);
    checkValue({tag, ".sel"}, 32'(digitSel0), 32'(expSel));
    checkValue({tag, ".seg"}, 32'(segData0), 32'(expSeg));
    checkValue({tag, ".fs"},  32'(frameStart0), 32'(expFs));
    checkValue({tag, ".ack"}, 32'(updAck0), 32'(expAck));
  endtask

  task automatic tick();
    @(negedge clk);
    pos++;
  endtask

  task automatic waitTo(input int target);
    while (pos < target) tick();
  endtask

  // One-cycle load strobe in the current cycle; returns one cycle later.
  task automatic applyStimulus(input logic [15:0] bcdVal, input logic [3:0] dotsVal);
    load = 1'b1;
    bcd  = bcdVal;
    dots = dotsVal;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; bcd = '0; dots = '0; lz_en = 1'b0; blink_mask = '0;

    // Reset state and first frame after release
    @(negedge clk);
    checkOutput("reset", 4'b0000, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    pos = 0;
    checkOutput("firstFs", 4'b0000, 8'h00, 1'b1, 1'b0);

    // Basic load: stays pending through frame 0, visible from frame 1
    waitTo(2);
    applyStimulus(16'h1234, 4'b0000);
    waitTo(13);
    checkOutput("pendHidden", 4'b1000, 8'b11111100, 1'b0, 1'b0);
    waitTo(16);
    checkOutput("swap1234", 4'b0000, 8'h00, 1'b1, 1'b1);
    waitTo(17);
    checkOutput("slot0", 4'b0001, 8'b01100110, 1'b0, 1'b0);
    waitTo(19);
    checkOutput("slot0last", 4'b0001, 8'b01100110, 1'b0, 1'b0);
    waitTo(20);
    checkOutput("slot1dead", 4'b0000, 8'h00, 1'b0, 1'b0);
    waitTo(21);
    checkOutput("slot1", 4'b0010, 8'b11110010, 1'b0, 1'b0);
    waitTo(25);
    checkOutput("slot2", 4'b0100, 8'b11011010, 1'b0, 1'b0);
    waitTo(29);
    checkOutput("slot3", 4'b1000, 8'b01100000, 1'b0, 1'b0);

    // Leading-zero blanking
    waitTo(32);
    lz_en = 1'b1;
    waitTo(34);
    applyStimulus(16'h0007, 4'b0000);
    waitTo(48);
    checkOutput("lzSwap", 4'b0000, 8'h00, 1'b1, 1'b1);
    waitTo(49);
    checkOutput("lz7s0", 4'b0001, 8'b11100000, 1'b0, 1'b0);
    waitTo(50);
    applyStimulus(16'h0000, 4'b1000);
    waitTo(53);
    checkOutput("lz7s1", 4'b0010, 8'h00, 1'b0, 1'b0);
    waitTo(57);
    checkOutput("lz7s2", 4'b0100, 8'h00, 1'b0, 1'b0);
    waitTo(61);
    checkOutput("lz7s3", 4'b1000, 8'h00, 1'b0, 1'b0);
    waitTo(64);
    checkOutput("lz0Swap", 4'b0000, 8'h00, 1'b1, 1'b1);
    waitTo(65);
    checkOutput("lz0s0", 4'b0001, 8'b11111100, 1'b0, 1'b0);
    waitTo(69);
    checkOutput("lz0s1", 4'b0010, 8'h00, 1'b0, 1'b0);
    waitTo(77);
    checkOutput("lz0dp", 4'b1000, 8'b00000001, 1'b0, 1'b0);

    // Mid-frame reset discards a pending load
    waitTo(80);
    lz_en = 1'b0;
    waitTo(82);
    applyStimulus(16'h5678, 4'b1111);
    waitTo(89);
    checkOutput("preRst", 4'b0100, 8'b11111100, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    checkOutput("midRst", 4'b0000, 8'h00, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    pos = 0;
    checkOutput("rstFs", 4'b0000, 8'h00, 1'b1, 1'b0);
    waitTo(1);
    checkOutput("rstD0", 4'b0001, 8'b11111100, 1'b0, 1'b0);
    waitTo(5);
    checkOutput("rstD1", 4'b0010, 8'b11111100, 1'b0, 1'b0);
    waitTo(9);
    checkOutput("rstD2", 4'b0100, 8'b11111100, 1'b0, 1'b0);
    waitTo(13);
    checkOutput("rstD3", 4'b1000, 8'b11111100, 1'b0, 1'b0);
    waitTo(16);
    checkOutput("noStaleAck", 4'b0000, 8'h00, 1'b1, 1'b0);
    waitTo(17);
    checkOutput("noStaleData", 4'b0001, 8'b11111100, 1'b0, 1'b0);

    // Blink: load sampled on the release edge is active in frame 0
    rst_n = 1'b0;
    blink_mask = 4'b0001;
    tick();
    rst_n = 1'b1;
    load  = 1'b1;
    bcd   = 16'h0008;
    dots  = 4'b0000;
    @(negedge clk);
    pos  = 0;
    load = 1'b0;
    checkOutput("blinkFs", 4'b0000, 8'h00, 1'b1, 1'b1);
    waitTo(1);
    checkOutput("blinkF0", 4'b0001, 8'b11111110, 1'b0, 1'b0);
    waitTo(17);
    checkOutput("blinkF1", 4'b0001, 8'b11111110, 1'b0, 1'b0);
    waitTo(33);
    checkOutput("blinkF2", 4'b0001, 8'h00, 1'b0, 1'b0);
    waitTo(37);
    checkOutput("blinkUnmasked", 4'b0010, 8'b11111100, 1'b0, 1'b0);
    waitTo(49);
    checkOutput("blinkF3", 4'b0001, 8'h00, 1'b0, 1'b0);
    waitTo(65);
    checkOutput("blinkF4", 4'b0001, 8'b11111110, 1'b0, 1'b0);
    blink_mask = 4'b0000;

    // Last load before a swap wins; a load in the frame_start cycle waits a frame
    waitTo(82);
    applyStimulus(16'h1111, 4'b0000);
    waitTo(85);
    applyStimulus(16'h2222, 4'b0000);
    waitTo(96);
    checkOutput("lastWinsFs", 4'b0000, 8'h00, 1'b1, 1'b1);
    applyStimulus(16'h3333, 4'b0000);
    checkOutput("lastWins", 4'b0001, 8'b11011010, 1'b0, 1'b0);
    waitTo(101);
    checkOutput("fsLoadHeld", 4'b0010, 8'b11011010, 1'b0, 1'b0);
    waitTo(112);
    checkOutput("fsLoadFs", 4'b0000, 8'h00, 1'b1, 1'b1);
    waitTo(113);
    checkOutput("fsLoadShown", 4'b0001, 8'b11110010, 1'b0, 1'b0);

    // Hex code A with a dot on digit 0, decimal-only and hex builds
    waitTo(114);
    applyStimulus(16'h000A, 4'b0001);
    waitTo(128);
    checkValue("hexAck", 32'(updAck0), 32'd1);
    waitTo(129);
    checkOutput("hexOff", 4'b0001, 8'b00000001, 1'b0, 1'b0);
    checkValue("hexOn.seg", 32'(segData1), 32'b11101111);
    checkValue("hexOn.sel", 32'(digitSel1), 32'b0001);
    waitTo(133);
    checkValue("hexOnD1.seg", 32'(segData1), 32'b11111100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
